// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types for the sram_group write path, plus the helper that
// converts a write-request command into the per-SRAM instruction payload.
package vector_cache_pkg;

    localparam int WR_INIT_LANES = 8;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] id;
    } txnid_t;

    typedef struct packed {
        logic [7:0] index;
        logic [1:0] way;
        logic [2:0] dest_ram_id;
        txnid_t     txnid;
        logic [1:0] opcode;
    } ram_req_cmd_t;

    typedef struct packed {
        ram_req_cmd_t req_cmd_pld;
        logic [3:0]   req_num;
    } write_ram_cmd_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] mode;
        logic [3:0] byte_sel;
        logic [2:0] dest_ram_id;
        txnid_t     txnid;
        logic [1:0] opcode;
    } sram_inst_cmd_t;

    typedef struct packed {
        sram_inst_cmd_t cmd_pld;
        logic [31:0]    data;
    } data_pld_t;

    typedef struct packed {
        write_ram_cmd_t cmd;
        logic [31:0]    data;
    } wr_fifo_entry_t;

    function automatic sram_inst_cmd_t wr_cmd_to_inst(input write_ram_cmd_t c);
        sram_inst_cmd_t s;
        s.addr        = {c.req_cmd_pld.index, c.req_cmd_pld.way};
        s.mode        = c.req_cmd_pld.txnid.mode;
        s.byte_sel    = c.req_num;
        s.dest_ram_id = c.req_cmd_pld.dest_ram_id;
        s.txnid       = c.req_cmd_pld.txnid;
        s.opcode      = c.req_cmd_pld.opcode;
        return s;
    endfunction

endpackage

// File: rtl/ram_write_initiator_lane_fifo.sv
// wr_lane_fifo: single-lane synchronous FIFO with registered occupancy count.
// Full is derived from the registered count only, so a same-cycle pop never raises it.
module wr_lane_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the count and pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ram_write_initiator.sv
// East-end write transmitter: per-lane FIFO, cmd beat then data beat one cycle later,
// and a delayed completion pulse. Optional perf counters under VC_WR_INIT_PERF_EN.
module ram_write_initiator
    import vector_cache_pkg::*;
#(
    parameter int LANES      = WR_INIT_LANES,
    parameter int FIFO_DEPTH = 4,
    parameter int DONE_LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic           [LANES-1:0]   up_wr_vld,
    output logic           [LANES-1:0]   up_wr_rdy,
    input  write_ram_cmd_t [LANES-1:0]   up_wr_cmd,
    input  logic [LANES-1:0][31:0]       up_wr_data,
    input  logic           [LANES-1:0]   rd_slot_busy,
    output logic           [LANES-1:0]   wr_cmd_vld_out,
    output write_ram_cmd_t [LANES-1:0]   wr_cmd_pld_out,
    output logic           [LANES-1:0]   wr_data_vld_out,
    output data_pld_t      [LANES-1:0]   wr_data_out,
    output logic           [LANES-1:0]   wr_done_vld,
    output txnid_t         [LANES-1:0]   wr_done_txnid
`ifdef VC_WR_INIT_PERF_EN
    ,
    output logic [LANES-1:0][15:0]       perf_launch_cnt,
    output logic [LANES-1:0][15:0]       perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic           [LANES-1:0]              fifo_full;
    logic           [LANES-1:0][CNT_W-1:0]   fifo_count;
    logic           [LANES-1:0]              pop;
    wr_fifo_entry_t [LANES-1:0]              push_entry;
    wr_fifo_entry_t [LANES-1:0]              head_entry;

    logic           [LANES-1:0]              cmd_vld_q;
    write_ram_cmd_t [LANES-1:0]              cmd_pld_q;
    logic [LANES-1:0][31:0]                  cmd_data_q;
    logic           [LANES-1:0]              data_vld_q;
    data_pld_t      [LANES-1:0]              data_out_q;
    data_pld_t      [LANES-1:0]              data_out_d;
    logic [LANES-1:0][DONE_LAT-1:0]          done_vld_q;
    txnid_t [LANES-1:0][DONE_LAT-1:0]        done_txn_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign push_entry[g] = '{cmd: up_wr_cmd[g], data: up_wr_data[g]};
        assign up_wr_rdy[g]  = !fifo_full[g];
        assign pop[g]        = (fifo_count[g] != '0) && !rd_slot_busy[g];

        wr_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (wr_fifo_entry_t)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (up_wr_vld[g] && up_wr_rdy[g]),
            .data_i  (push_entry[g]),
            .pop_i   (pop[g]),
            .data_o  (head_entry[g]),
            .full_o  (fifo_full[g]),
            .count_o (fifo_count[g])
        );
    end

    always_comb begin
        data_out_d = data_out_q;
        for (int l = 0; l < LANES; l++) begin
            data_out_d[l] = '{cmd_pld: wr_cmd_to_inst(cmd_pld_q[l]), data: cmd_data_q[l]};
        end
    end

    // Payload registers only load alongside a valid beat so they hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld_q  <= '0;
            cmd_pld_q  <= '0;
            cmd_data_q <= '0;
            data_vld_q <= '0;
            data_out_q <= '0;
            done_vld_q <= '0;
            done_txn_q <= '0;
        end else begin
            cmd_vld_q  <= pop;
            data_vld_q <= cmd_vld_q;
            for (int l = 0; l < LANES; l++) begin
                if (pop[l]) begin
                    cmd_pld_q[l]  <= head_entry[l].cmd;
                    cmd_data_q[l] <= head_entry[l].data;
                end
                if (cmd_vld_q[l]) data_out_q[l] <= data_out_d[l];
                done_vld_q[l][0] <= data_vld_q[l];
                if (data_vld_q[l]) done_txn_q[l][0] <= data_out_q[l].cmd_pld.txnid;
                for (int k = 1; k < DONE_LAT; k++) begin
                    done_vld_q[l][k] <= done_vld_q[l][k-1];
                    if (done_vld_q[l][k-1]) done_txn_q[l][k] <= done_txn_q[l][k-1];
                end
            end
        end
    end

    always_comb begin
        wr_done_vld   = '0;
        wr_done_txnid = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_done_vld[l]   = done_vld_q[l][DONE_LAT-1];
            wr_done_txnid[l] = done_txn_q[l][DONE_LAT-1];
        end
    end

    assign wr_cmd_vld_out  = cmd_vld_q;
    assign wr_cmd_pld_out  = cmd_pld_q;
    assign wr_data_vld_out = data_vld_q;
    assign wr_data_out     = data_out_q;

`ifdef VC_WR_INIT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_launch_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (pop[l] && (perf_launch_cnt[l] != 16'hFFFF))
                    perf_launch_cnt[l] <= perf_launch_cnt[l] + 16'd1;
                if ((fifo_count[l] != '0) && rd_slot_busy[l] && (perf_stall_cnt[l] != 16'hFFFF))
                    perf_stall_cnt[l] <= perf_stall_cnt[l] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_write_initiator.sv
// Directed self-checking bench for ram_write_initiator; each task owns one scenario.
// Build with VC_WR_INIT_PERF_EN defined to also exercise the perf counters.
module tb_ram_write_initiator;
    import vector_cache_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic           [7:0]   up_wr_vld;
    logic           [7:0]   up_wr_rdy;
    write_ram_cmd_t [7:0]   up_wr_cmd;
    logic [7:0][31:0]       up_wr_data;
    logic           [7:0]   rd_slot_busy;
    logic           [7:0]   wr_cmd_vld_out;
    write_ram_cmd_t [7:0]   wr_cmd_pld_out;
    logic           [7:0]   wr_data_vld_out;
    data_pld_t      [7:0]   wr_data_out;
    logic           [7:0]   wr_done_vld;
    txnid_t         [7:0]   wr_done_txnid;
`ifdef VC_WR_INIT_PERF_EN
    logic [7:0][15:0]       perf_launch_cnt;
    logic [7:0][15:0]       perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ram_write_initiator #(
        .LANES      (8),
        .FIFO_DEPTH (4),
        .DONE_LAT   (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .up_wr_vld       (up_wr_vld),
        .up_wr_rdy       (up_wr_rdy),
        .up_wr_cmd       (up_wr_cmd),
        .up_wr_data      (up_wr_data),
        .rd_slot_busy    (rd_slot_busy),
        .wr_cmd_vld_out  (wr_cmd_vld_out),
        .wr_cmd_pld_out  (wr_cmd_pld_out),
        .wr_data_vld_out (wr_data_vld_out),
        .wr_data_out     (wr_data_out),
        .wr_done_vld     (wr_done_vld),
        .wr_done_txnid   (wr_done_txnid)
`ifdef VC_WR_INIT_PERF_EN
        ,
        .perf_launch_cnt (perf_launch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call moves to just after the next rising edge; that is the start of a new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic write_ram_cmd_t mk_cmd(input logic [7:0] idx, input logic [1:0] way,
                                              input logic [3:0] num, input logic [5:0] id,
                                              input logic [1:0] mode, input logic [2:0] dest);
        write_ram_cmd_t c;
        c = '0;
        c.req_cmd_pld.index       = idx;
        c.req_cmd_pld.way         = way;
        c.req_cmd_pld.dest_ram_id = dest;
        c.req_cmd_pld.txnid.id    = id;
        c.req_cmd_pld.txnid.mode  = mode;
        c.req_cmd_pld.opcode      = 2'b10;
        c.req_num                 = num;
        return c;
    endfunction

    task automatic clear_inputs();
        up_wr_vld    = '0;
        up_wr_cmd    = '0;
        up_wr_data   = '0;
        rd_slot_busy = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'h00 || wr_data_vld_out !== 8'h00 || wr_done_vld !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_vld: got cmd=%h data=%h done=%h required all 00",
                     wr_cmd_vld_out, wr_data_vld_out, wr_done_vld);
        end
        checks++;
        if (up_wr_rdy !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_rdy: got %h required ff", up_wr_rdy);
        end
        checks++;
        if (wr_cmd_pld_out !== '0 || wr_data_out !== '0 || wr_done_txnid !== '0) begin
            errors++;
            $display("[TB] FAIL reset_pld: got nonzero payload outputs, required zero");
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        write_ram_cmd_t c;
        do_reset();
        c = mk_cmd(8'd5, 2'd1, 4'd2, 6'h2A, 2'd2, 3'd3);
        up_wr_vld[3]  = 1'b1;
        up_wr_cmd[3]  = c;
        up_wr_data[3] = 32'hDEAD_BEEF;
        tick();
        up_wr_vld = '0;
        checks++;
        if (wr_cmd_vld_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_c1_nobypass: got cmd_vld=%h required 00", wr_cmd_vld_out);
        end
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'h08 || wr_cmd_pld_out[3] !== c) begin
            errors++;
            $display("[TB] FAIL single_c2_cmd: got vld=%h pld=%h required vld=08 pld=%h",
                     wr_cmd_vld_out, wr_cmd_pld_out[3], c);
        end
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'h00 || wr_data_vld_out !== 8'h08) begin
            errors++;
            $display("[TB] FAIL single_c3_vld: got cmd=%h data=%h required cmd=00 data=08",
                     wr_cmd_vld_out, wr_data_vld_out);
        end
        checks++;
        if (wr_data_out[3].data !== 32'hDEAD_BEEF || wr_data_out[3].cmd_pld.addr !== 10'h015 ||
            wr_data_out[3].cmd_pld.byte_sel !== 4'd2) begin
            errors++;
            $display("[TB] FAIL single_c3_data: got data=%h addr=%h byte_sel=%h required deadbeef 015 2",
                     wr_data_out[3].data, wr_data_out[3].cmd_pld.addr, wr_data_out[3].cmd_pld.byte_sel);
        end
        checks++;
        if (wr_data_out[3].cmd_pld.mode !== 2'd2 || wr_data_out[3].cmd_pld.dest_ram_id !== 3'd3 ||
            wr_data_out[3].cmd_pld.txnid !== 8'hAA || wr_data_out[3].cmd_pld.opcode !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_c3_fields: got mode=%h dest=%h txnid=%h op=%h required 2 3 aa 2",
                     wr_data_out[3].cmd_pld.mode, wr_data_out[3].cmd_pld.dest_ram_id,
                     wr_data_out[3].cmd_pld.txnid, wr_data_out[3].cmd_pld.opcode);
        end
        tick();
        checks++;
        if (wr_done_vld !== 8'h00 || wr_data_vld_out !== 8'h00 || wr_cmd_pld_out[3] !== c) begin
            errors++;
            $display("[TB] FAIL single_c4_hold: got done=%h data=%h pld=%h required 00 00 %h",
                     wr_done_vld, wr_data_vld_out, wr_cmd_pld_out[3], c);
        end
        tick();
        checks++;
        if (wr_done_vld !== 8'h08 || wr_done_txnid[3] !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL single_c5_done: got done=%h txnid=%h required 08 aa",
                     wr_done_vld, wr_done_txnid[3]);
        end
        tick();
        checks++;
        if (wr_done_vld !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_c6_done_pulse: got %h required 00", wr_done_vld);
        end
    endtask

    // Lane 0 is held busy while four entries fill the FIFO, then released so six
    // entries drain on consecutive cycles with the fifth and sixth pushed behind them.
    task automatic test_back_to_back();
        int idx;
        logic expVld;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            rd_slot_busy[0] = (c < 4);
            up_wr_vld[0]    = (c <= 6);
            idx = (c < 4) ? c : ((c <= 5) ? 4 : 5);
            up_wr_cmd[0]    = mk_cmd(8'(16 + idx), 2'(idx), 4'(idx), 6'(idx), 2'(idx), 3'd0);
            up_wr_data[0]   = 32'hB000_0000 + 32'(idx);
            if (c <= 6) begin
                checks++;
                if (up_wr_rdy[0] !== (c != 4)) begin
                    errors++;
                    $display("[TB] FAIL b2b_rdy_c%0d: got %b required %b", c, up_wr_rdy[0], (c != 4));
                end
            end
            expVld = (c >= 5 && c <= 10);
            checks++;
            if (wr_cmd_vld_out[0] !== expVld ||
                (expVld && wr_cmd_pld_out[0] !== mk_cmd(8'(11 + c), 2'(c - 5), 4'(c - 5), 6'(c - 5), 2'(c - 5), 3'd0))) begin
                errors++;
                $display("[TB] FAIL b2b_cmd_c%0d: got vld=%b pld=%h required vld=%b entry %0d",
                         c, wr_cmd_vld_out[0], wr_cmd_pld_out[0], expVld, c - 5);
            end
            expVld = (c >= 6 && c <= 11);
            checks++;
            if (wr_data_vld_out[0] !== expVld ||
                (expVld && wr_data_out[0].data !== 32'hB000_0000 + 32'(c - 6))) begin
                errors++;
                $display("[TB] FAIL b2b_data_c%0d: got vld=%b data=%h required vld=%b data=%h",
                         c, wr_data_vld_out[0], wr_data_out[0].data, expVld, 32'hB000_0000 + 32'(c - 6));
            end
            tick();
        end
        clear_inputs();
    endtask

    // Lane 5 holds two entries behind a read reservation; lane 2 launches meanwhile.
    task automatic test_read_busy();
        logic expVld;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            up_wr_vld[5]    = (c <= 1);
            up_wr_cmd[5]    = mk_cmd(8'(40 + c), 2'd3, 4'(c), 6'(20 + c), 2'd1, 3'd5);
            up_wr_data[5]   = 32'h5500_0000 + 32'(c);
            up_wr_vld[2]    = (c == 0);
            up_wr_cmd[2]    = mk_cmd(8'd7, 2'd0, 4'd1, 6'd9, 2'd0, 3'd2);
            up_wr_data[2]   = 32'h2222_2222;
            rd_slot_busy[5] = (c >= 1 && c <= 10);
            expVld = (c == 12 || c == 13);
            checks++;
            if (wr_cmd_vld_out[5] !== expVld ||
                (expVld && wr_cmd_pld_out[5] !== mk_cmd(8'(28 + c), 2'd3, 4'(c - 12), 6'(8 + c), 2'd1, 3'd5))) begin
                errors++;
                $display("[TB] FAIL busy_l5_cmd_c%0d: got vld=%b pld=%h required vld=%b",
                         c, wr_cmd_vld_out[5], wr_cmd_pld_out[5], expVld);
            end
            expVld = (c == 13 || c == 14);
            checks++;
            if (wr_data_vld_out[5] !== expVld ||
                (expVld && wr_data_out[5].data !== 32'h5500_0000 + 32'(c - 13))) begin
                errors++;
                $display("[TB] FAIL busy_l5_data_c%0d: got vld=%b data=%h required vld=%b",
                         c, wr_data_vld_out[5], wr_data_out[5].data, expVld);
            end
            checks++;
            if ((wr_cmd_vld_out & 8'hDF) !== ((c == 2) ? 8'h04 : 8'h00)) begin
                errors++;
                $display("[TB] FAIL busy_others_c%0d: got cmd_vld=%h required %h",
                         c, wr_cmd_vld_out & 8'hDF, (c == 2) ? 8'h04 : 8'h00);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_all_lanes();
        do_reset();
        for (int l = 0; l < 8; l++) begin
            up_wr_vld[l]  = 1'b1;
            up_wr_cmd[l]  = mk_cmd(8'(l), 2'(l), 4'(l), 6'(l + 1), 2'd3, 3'(l));
            up_wr_data[l] = 32'hA0A0_0000 + 32'(l);
        end
        tick();
        clear_inputs();
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'hFF || wr_data_vld_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL all_c2: got cmd=%h data=%h required ff 00", wr_cmd_vld_out, wr_data_vld_out);
        end
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'h00 || wr_data_vld_out !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL all_c3: got cmd=%h data=%h required 00 ff", wr_cmd_vld_out, wr_data_vld_out);
        end
        for (int l = 0; l < 8; l++) begin
            checks++;
            if (wr_data_out[l].data !== 32'hA0A0_0000 + 32'(l) ||
                wr_data_out[l].cmd_pld.addr !== {8'(l), 2'(l)}) begin
                errors++;
                $display("[TB] FAIL all_data_l%0d: got data=%h addr=%h required %h %h", l,
                         wr_data_out[l].data, wr_data_out[l].cmd_pld.addr,
                         32'hA0A0_0000 + 32'(l), {8'(l), 2'(l)});
            end
        end
        tick();
        tick();
        checks++;
        if (wr_done_vld !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL all_done: got %h required ff", wr_done_vld);
        end
        for (int l = 0; l < 8; l++) begin
            checks++;
            if (wr_done_txnid[l] !== {2'd3, 6'(l + 1)}) begin
                errors++;
                $display("[TB] FAIL all_txnid_l%0d: got %h required %h", l, wr_done_txnid[l], {2'd3, 6'(l + 1)});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        up_wr_vld[1]  = 1'b1;
        up_wr_cmd[1]  = mk_cmd(8'd3, 2'd2, 4'd1, 6'd4, 2'd1, 3'd1);
        up_wr_data[1] = 32'h1234_5678;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (wr_cmd_vld_out !== 8'h02) begin
            errors++;
            $display("[TB] FAIL rstmid_cmd: got %h required 02", wr_cmd_vld_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_cmd_vld_out !== 8'h00 || wr_cmd_pld_out !== '0 || wr_data_vld_out !== 8'h00 ||
            wr_data_out !== '0 || wr_done_vld !== 8'h00 || wr_done_txnid !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear: got cmd=%h data=%h done=%h required all zero",
                     wr_cmd_vld_out, wr_data_vld_out, wr_done_vld);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (wr_data_vld_out !== 8'h00 || wr_done_vld !== 8'h00 || wr_cmd_vld_out !== 8'h00 ||
                up_wr_rdy !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL rstmid_after_c%0d: got cmd=%h data=%h done=%h rdy=%h required 00 00 00 ff",
                         c, wr_cmd_vld_out, wr_data_vld_out, wr_done_vld, up_wr_rdy);
            end
            tick();
        end
    endtask

`ifdef VC_WR_INIT_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            up_wr_vld[2]    = (c <= 2);
            up_wr_cmd[2]    = mk_cmd(8'(c), 2'd0, 4'd0, 6'(c), 2'd0, 3'd2);
            up_wr_data[2]   = 32'(c);
            rd_slot_busy[2] = (c >= 1 && c <= 4);
            tick();
        end
        clear_inputs();
        checks++;
        if (perf_launch_cnt[2] !== 16'd3 || perf_stall_cnt[2] !== 16'd4) begin
            errors++;
            $display("[TB] FAIL perf_lane2: got launch=%0d stall=%0d required 3 4",
                     perf_launch_cnt[2], perf_stall_cnt[2]);
        end
        checks++;
        if (perf_launch_cnt[0] !== 16'd0 || perf_stall_cnt[0] !== 16'd0) begin
            errors++;
            $display("[TB] FAIL perf_lane0: got launch=%0d stall=%0d required 0 0",
                     perf_launch_cnt[0], perf_stall_cnt[0]);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_busy();
        test_all_lanes();
        test_reset_mid();
`ifdef VC_WR_INIT_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
